// File: rtl/rom_image_loader.sv
// Streams a memory image into a RAM write port, then reads the RAM back and
// compares additive 16-bit checksums of the written and read-back data.
module rom_image_loader #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 128,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           load_sum
);

    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   wcount;
    logic [ADDR_WIDTH-1:0]   rcount;
    logic [15:0]             read_sum;
    logic [READ_LATENCY-1:0] vpipe;
    logic [READ_LATENCY-1:0] vpipe_next;
    logic [READ_LATENCY:0]   vshift;
    logic                    handshake;
    logic                    start_ok;
    logic                    last_w;
    logic                    last_r;

    // Pipeline contents after the coming edge; DRAIN ends once this is empty.
    assign vshift     = {vpipe, mem_re};
    assign vpipe_next = vshift[READ_LATENCY-1:0];
    assign handshake  = in_valid & in_ready;
    assign start_ok   = start & ((state == IDLE) | (state == DONE));
    assign last_w     = (wcount == LAST);
    assign last_r     = (rcount == LAST);

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (start) state_next = LOAD;
            LOAD:  if (handshake && last_w) state_next = READ;
            READ:  if (last_r) state_next = DRAIN;
            DRAIN: if (vpipe_next == '0) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state == LOAD) | (state == READ) | (state == DRAIN);
        done     = (state == DONE);
        pass     = (state == DONE) & (read_sum == load_sum);
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            wcount    <= '0;
            rcount    <= '0;
            load_sum  <= '0;
            read_sum  <= '0;
            vpipe     <= '0;
        end else begin
            mem_we <= handshake;
            if (handshake) begin
                mem_waddr <= wcount;
                mem_wdata <= in_data;
                load_sum  <= load_sum + 16'(in_data);
                if (!last_w) wcount <= wcount + 1'b1;
            end
            mem_re <= (state == READ);
            if (state == READ) begin
                mem_raddr <= rcount;
                if (!last_r) rcount <= rcount + 1'b1;
            end
            vpipe <= vpipe_next;
            if (vpipe[READ_LATENCY-1]) read_sum <= read_sum + 16'(mem_rdata);
            if (start_ok) begin
                load_sum <= '0;
                read_sum <= '0;
                wcount   <= '0;
                rcount   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rom_image_loader.sv
// Directed bench: two loaders (read latency 1 and 3) share the image stream,
// each with its own RAM model; checks sums, write/read sweeps, timing, resets.
module tb_rom_image_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       corrupt;
    logic       mon_clr;

    logic       rdy1, we1, re1, busy1, done1, pass1;
    logic [6:0] waddr1, raddr1;
    logic [7:0] wdata1, rdata1;
    logic [15:0] sum1;
    logic       rdy3, we3, re3, busy3, done3, pass3;
    logic [6:0] waddr3, raddr3;
    logic [7:0] wdata3, rdata3;
    logic [15:0] sum3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;
    int d1, d3;
    int we_n, re_n, we_bad, re_bad;

    rom_image_loader #(.READ_LATENCY(1)) u1 (
        .clock0(clk), .reset(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
        .mem_we(we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
        .mem_re(re1), .mem_raddr(raddr1), .mem_rdata(rdata1),
        .busy(busy1), .done(done1), .pass(pass1), .load_sum(sum1)
    );

    rom_image_loader #(.READ_LATENCY(3)) u3 (
        .clock0(clk), .reset(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy3),
        .mem_we(we3), .mem_waddr(waddr3), .mem_wdata(wdata3),
        .mem_re(re3), .mem_raddr(raddr3), .mem_rdata(rdata3),
        .busy(busy3), .done(done3), .pass(pass3), .load_sum(sum3)
    );

    logic [7:0] mem1 [128];
    logic [7:0] mem3 [128];
    logic [7:0] p3a, p3b, p3c;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM models; corrupt flips bit 0 of address 5 on the read path
    always @(posedge clk) begin
        if (we1) mem1[waddr1] <= wdata1;
        if (re1) rdata1 <= mem1[raddr1] ^ {7'd0, corrupt && raddr1 == 7'd5};
    end

    always @(posedge clk) begin
        if (we3) mem3[waddr3] <= wdata3;
        if (re3) p3a <= mem3[raddr3] ^ {7'd0, corrupt && raddr3 == 7'd5};
        p3b <= p3a;
        p3c <= p3b;
    end
    assign rdata3 = p3c;

    always @(posedge clk) begin
        if (mon_clr) begin
            we_n <= 0; re_n <= 0; we_bad <= 0; re_bad <= 0;
        end else begin
            if (we1) begin
                if (int'(waddr1) != we_n) we_bad <= we_bad + 1;
                we_n <= we_n + 1;
            end
            if (re1) begin
                if (int'(raddr1) != re_n) re_bad <= re_bad + 1;
                re_n <= re_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        mon_clr = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mon_clr = 1'b0;
        t_start = cyc;
    endtask

    task automatic feed(input int kind, input bit toggle, input int n,
                        input bit hold);
        int idx = 0;
        int k = 0;
        bit ph = 1'b1;
        bit hs;
        while (idx < n && k < 1000) begin
            in_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            in_data = (kind == 1) ? 8'hFF : 8'(idx);
            hs = in_valid && rdy1;
            @(negedge clk);
            if (hs) idx++;
            k++;
        end
        in_valid = hold;
        chk("feed_count", idx, n);
    endtask

    task automatic wait_done();
        int k = 0;
        d1 = -1;
        d3 = -1;
        while ((d1 < 0 || d3 < 0) && k < 400) begin
            if (done1 && d1 < 0) d1 = cyc - t_start;
            if (done3 && d3 < 0) d3 = cyc - t_start;
            @(negedge clk);
            k++;
        end
        chk("done_timeout", (d1 > 0) && (d3 > 0), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; corrupt = 1'b0; mon_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy1, 0);
        chk("rst_we_re", {we1, re1}, 0);
        chk("rst_busy_done_pass", {busy1, done1, pass1}, 0);
        chk("rst_sum", sum1, 0);
        rst = 1'b0;

        // incrementing image, in_valid held high through READ
        do_start();
        chk("t1_busy", busy1, 1);
        chk("t1_ready", rdy1, 1);
        feed(0, 1'b0, 128, 1'b1);
        chk("t1_ready_read", {rdy1, rdy3}, 0);
        wait_done();
        in_valid = 1'b0;
        chk("t1_sum", sum1, 32'h1FC0);
        chk("t1_we_n", we_n, 128);
        chk("t1_we_addr", we_bad, 0);
        chk("t1_re_n", re_n, 128);
        chk("t1_re_addr", re_bad, 0);
        chk("t1_done", done1, 1);
        chk("t1_pass", {pass1, pass3}, 2'b11);
        chk("t1_lat1_bound", d1 <= 261, 1);
        chk("t1_lat3_bound", d3 <= 263, 1);
        chk("t1_lat_delta", d3 - d1, 2);

        // all 0xFF
        do_start();
        feed(1, 1'b0, 128, 1'b0);
        wait_done();
        chk("t2_sum1", sum1, 32'h7F80);
        chk("t2_sum3", sum3, 32'h7F80);
        chk("t2_pass", {pass1, pass3}, 2'b11);
        chk("t2_lat_delta", d3 - d1, 2);

        // read-back corruption at address 5
        corrupt = 1'b1;
        do_start();
        feed(0, 1'b0, 128, 1'b0);
        wait_done();
        chk("t3_done", {done1, done3}, 2'b11);
        chk("t3_pass", {pass1, pass3}, 2'b00);
        chk("t3_sum", sum1, 32'h1FC0);
        corrupt = 1'b0;

        // gappy stream, start pulsed during READ
        do_start();
        feed(0, 1'b1, 128, 1'b0);
        chk("t4_ready_read", rdy1, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_after_start", busy1, 1);
        chk("t4_ready_after_start", rdy1, 0);
        wait_done();
        chk("t4_we_n", we_n, 128);
        chk("t4_we_addr", we_bad, 0);
        chk("t4_re_n", re_n, 128);
        chk("t4_pass", {pass1, pass3}, 2'b11);
        chk("t4_sum", sum1, 32'h1FC0);

        // reset after 40 bytes, then fresh full load
        do_start();
        feed(0, 1'b0, 40, 1'b0);
        chk("t5_sum40", sum1, 32'h030C);
        chk("t5_last_we", {we1, waddr1, wdata1}, {1'b1, 7'd39, 8'h27});
        rst = 1'b1;
        #1;
        chk("t5_rst_we", {we1, waddr1, wdata1}, 0);
        chk("t5_rst_re", {re1, raddr1}, 0);
        chk("t5_rst_flags", {rdy1, busy1, done1, pass1}, 0);
        chk("t5_rst_sum", sum1, 0);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        feed(0, 1'b0, 128, 1'b0);
        wait_done();
        chk("t5_sum", sum1, 32'h1FC0);
        chk("t5_we_n", we_n, 128);
        chk("t5_pass", {pass1, pass3}, 2'b11);

        // back-to-back start from DONE
        chk("t6_in_done", done1, 1);
        do_start();
        chk("t6_done_drop", done1, 0);
        chk("t6_busy", busy1, 1);
        feed(1, 1'b0, 128, 1'b0);
        wait_done();
        chk("t6_we_addr", we_bad, 0);
        chk("t6_we_n", we_n, 128);
        chk("t6_sum", sum1, 32'h7F80);
        chk("t6_pass", {pass1, pass3}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_image_loader.md
Name: rom_image_loader

Overview:
- Synthesizable writer/verifier for the ROM-image path.
- Accepts a byte stream (valid/ready) holding a memory image and writes it to sequential addresses of a synchronous RAM write port.
- Then sweeps the whole RAM through its read port and compares a 16-bit additive checksum of the read-back data against the checksum of the data that was written.
- Reports busy/done/pass; sits between the image source (bitstream/pad logic) and the ROM/RAM macro it initialises.

Parameters:
- ADDR_WIDTH, 7: RAM address width.
- DATA_WIDTH, 8: RAM data width.
- DEPTH, 128: number of words loaded and verified. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from the clock edge that samples mem_re to mem_rdata being valid. Legal range 1..4.

Ports:
- clock0, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: begin load; sampled only in IDLE or DONE.
- in_data, in, DATA_WIDTH: image byte.
- in_valid, in, 1: in_data valid.
- in_ready, out, 1: loader accepts in_data this cycle.
- mem_we, out, 1: RAM write enable (registered).
- mem_waddr, out, ADDR_WIDTH: RAM write address (registered).
- mem_wdata, out, DATA_WIDTH: RAM write data (registered).
- mem_re, out, 1: RAM read enable (registered).
- mem_raddr, out, ADDR_WIDTH: RAM read address (registered).
- mem_rdata, in, DATA_WIDTH: RAM read data.
- busy, out, 1: high in LOAD, READ and DRAIN.
- done, out, 1: high in DONE.
- pass, out, 1: checksum match; valid while done=1.
- load_sum, out, 16: running checksum of accepted bytes.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including counters, load_sum, the read-side sum and the latency pipeline. Any operation in progress is abandoned; no further mem_we/mem_re pulses.
- States: IDLE, LOAD, READ, DRAIN, DONE.
- IDLE/DONE, start=1:
  - Go to LOAD; clear load_sum, the read sum, the write counter and pass.
  - done drops the cycle after start is sampled.
  - start is ignored in LOAD, READ and DRAIN.
- LOAD:
  - in_ready=1 (combinational from state). Handshake = in_valid & in_ready.
  - On a handshake, the next cycle drives mem_we=1, mem_waddr=wcount, mem_wdata=in_data. Then wcount+1, and load_sum += zero-extended in_data (mod 2^16).
  - Without a handshake, mem_we=0 the next cycle; gaps of any length are allowed.
  - The handshake at wcount=DEPTH-1 moves to READ. in_ready is 0 from then on.
- READ:
  - mem_re=1 for exactly DEPTH consecutive cycles, with mem_raddr=0..DEPTH-1 ascending.
  - The first read is issued no earlier than the cycle after the last mem_we, so there is no read-before-write hazard.
  - A READ_LATENCY-deep valid shift pipeline marks returning data. Each marked mem_rdata adds to the read sum (mod 2^16).
  - After the last read issue, go to DRAIN.
- DRAIN: wait until the pipeline is empty (READ_LATENCY cycles), then go to DONE.
- DONE:
  - done=1 and pass=(read sum == load_sum), both held until the next start or reset.
  - load_sum holds its final value.
- Address counters never wrap within an operation. Sums wrap modulo 65536.
- in_valid outside LOAD has no effect and is not consumed.

Test Plan:
- Reset, start pulse, in_valid held high with bytes 0x00..0x7F; bench RAM model:
  - load_sum=0x1FC0;
  - mem_we seen 128 times at addresses 0..127;
  - mem_re seen 128 times;
  - done=1 with pass=1 within 2*DEPTH+READ_LATENCY+4 cycles of start.
- All bytes 0xFF -> load_sum=0x7F80, pass=1. Repeat with READ_LATENCY=3 -> pass=1, done 2 cycles later than with READ_LATENCY=1.
- Incrementing image, with the RAM model flipping bit 0 of address 5 on read -> done=1, pass=0, load_sum=0x1FC0.
- in_valid toggling 1/0 every cycle -> exactly 128 writes, in_ready low outside LOAD, pass=1. start pulsed during READ -> ignored, no restart.
- reset asserted after 40 accepted bytes -> all outputs 0 immediately, state IDLE. Fresh start with a full image -> load_sum counts only the new bytes, pass=1.
- Back-to-back: start asserted in the DONE cycle -> done falls next cycle, second load runs from address 0.
